// File: rtl/fp32_div_arbiter.sv
// fp32_div_arbiter
//   Shares one external IEEE-754 single-precision divider between two
//   requesting ports. Only one operation is in flight at any time: the
//   winning port's operand pair is accepted, forwarded to the divider as two
//   separate strobed transfers (a, then b), the quotient is collected and
//   handed back to the same port unmodified.
//
// Parameters
//   FAIR_RR      1: round-robin between ports, 0: fixed priority, port 0 first
//
// Ports
//   clock, reset                 single clock, synchronous active-high reset
//   reqN_a, reqN_b, reqN_stb     port N operand pair and its strobe (input)
//   reqN_ack                     port N operand pair accepted (output)
//   reqN_z, reqN_z_stb           port N quotient and its strobe (output)
//   reqN_z_ack                   port N quotient consumed (input)
//   div_a/div_b, *_stb, *_ack    operand transfers to the divider
//   div_z, div_z_stb, div_z_ack  quotient transfer from the divider
//   grant                        port owning the divider
//   busy                         high whenever the FSM is not idle
//   done_count0/1                completed operations per port (wrapping)
module fp32_div_arbiter #(
  parameter bit FAIR_RR = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_stb,
  output logic        req0_ack,
  output logic [31:0] req0_z,
  output logic        req0_z_stb,
  input  logic        req0_z_ack,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_stb,
  output logic        req1_ack,
  output logic [31:0] req1_z,
  output logic        req1_z_stb,
  input  logic        req1_z_ack,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_a_stb,
  output logic        div_b_stb,
  input  logic        div_a_ack,
  input  logic        div_b_ack,
  input  logic [31:0] div_z,
  input  logic        div_z_stb,
  output logic        div_z_ack,
  output logic        grant,
  output logic        busy,
  output logic [15:0] done_count0,
  output logic [15:0] done_count1
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    SEND_A = 3'd2,
    SEND_B = 3'd3,
    WAIT_Z = 3'd4,
    RETURN = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        req0_ack_q, req0_ack_d;
  logic        req1_ack_q, req1_ack_d;
  logic [31:0] req0_z_q, req0_z_d;
  logic [31:0] req1_z_q, req1_z_d;
  logic        req0_z_stb_q, req0_z_stb_d;
  logic        req1_z_stb_q, req1_z_stb_d;
  logic [31:0] div_a_q, div_a_d;
  logic [31:0] div_b_q, div_b_d;
  logic [31:0] b_lat_q, b_lat_d;
  logic        div_a_stb_q, div_a_stb_d;
  logic        div_b_stb_q, div_b_stb_d;
  logic        div_z_ack_q, div_z_ack_d;
  logic [15:0] done_count0_q, done_count0_d;
  logic [15:0] done_count1_q, done_count1_d;

  // Signals of whichever port currently owns the divider.
  logic        sel_stb_s;
  logic        sel_ack_s;
  logic        sel_z_stb_s;
  logic        sel_z_ack_s;
  logic [31:0] sel_a_s;
  logic [31:0] sel_b_s;
  // Port that would win arbitration this cycle: a lone requester always
  // wins; on contention round-robin favours the port not served last.
  logic        pick_s;

  assign sel_stb_s   = grant_q ? req1_stb     : req0_stb;
  assign sel_ack_s   = grant_q ? req1_ack_q   : req0_ack_q;
  assign sel_z_stb_s = grant_q ? req1_z_stb_q : req0_z_stb_q;
  assign sel_z_ack_s = grant_q ? req1_z_ack   : req0_z_ack;
  assign sel_a_s     = grant_q ? req1_a       : req0_a;
  assign sel_b_s     = grant_q ? req1_b       : req0_b;
  assign pick_s      = (req0_stb && req1_stb) ? (FAIR_RR ? ~last_q : 1'b0) : req1_stb;

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    req0_ack_d    = req0_ack_q;
    req1_ack_d    = req1_ack_q;
    req0_z_d      = req0_z_q;
    req1_z_d      = req1_z_q;
    req0_z_stb_d  = req0_z_stb_q;
    req1_z_stb_d  = req1_z_stb_q;
    div_a_d       = div_a_q;
    div_b_d       = div_b_q;
    b_lat_d       = b_lat_q;
    div_a_stb_d   = div_a_stb_q;
    div_b_stb_d   = div_b_stb_q;
    div_z_ack_d   = div_z_ack_q;
    done_count0_d = done_count0_q;
    done_count1_d = done_count1_q;
    case (state_q)
      IDLE: begin
        if (req0_stb || req1_stb) begin
          grant_d    = pick_s;
          req0_ack_d = ~pick_s;
          req1_ack_d = pick_s;
          state_d    = ACCEPT;
        end else begin
          state_d = IDLE;
        end
      end
      ACCEPT: begin
        // a goes straight into the divider operand register (that register
        // is the latch for a); b is held until the a transfer completes.
        if (sel_stb_s && sel_ack_s) begin
          div_a_d     = sel_a_s;
          b_lat_d     = sel_b_s;
          div_a_stb_d = 1'b1;
          req0_ack_d  = 1'b0;
          req1_ack_d  = 1'b0;
          state_d     = SEND_A;
        end else begin
          state_d = ACCEPT;
        end
      end
      SEND_A: begin
        if (div_a_stb_q && div_a_ack) begin
          div_a_stb_d = 1'b0;
          div_b_d     = b_lat_q;
          div_b_stb_d = 1'b1;
          state_d     = SEND_B;
        end else begin
          state_d = SEND_A;
        end
      end
      SEND_B: begin
        if (div_b_stb_q && div_b_ack) begin
          div_b_stb_d = 1'b0;
          div_z_ack_d = 1'b1;
          state_d     = WAIT_Z;
        end else begin
          state_d = SEND_B;
        end
      end
      WAIT_Z: begin
        // The quotient is latched directly into the owner's result register
        // so the other port's last result stays untouched.
        if (div_z_stb && div_z_ack_q) begin
          div_z_ack_d = 1'b0;
          if (grant_q) begin
            req1_z_d     = div_z;
            req1_z_stb_d = 1'b1;
          end else begin
            req0_z_d     = div_z;
            req0_z_stb_d = 1'b1;
          end
          state_d = RETURN;
        end else begin
          state_d = WAIT_Z;
        end
      end
      RETURN: begin
        if (sel_z_stb_s && sel_z_ack_s) begin
          req0_z_stb_d = 1'b0;
          req1_z_stb_d = 1'b0;
          last_d       = grant_q;
          if (grant_q) begin
            done_count1_d = done_count1_q + 16'd1;
          end else begin
            done_count0_d = done_count0_q + 16'd1;
          end
          state_d = IDLE;
        end else begin
          state_d = RETURN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      last_q        <= 1'b1;
      busy_q        <= 1'b0;
      req0_ack_q    <= 1'b0;
      req1_ack_q    <= 1'b0;
      req0_z_q      <= 32'd0;
      req1_z_q      <= 32'd0;
      req0_z_stb_q  <= 1'b0;
      req1_z_stb_q  <= 1'b0;
      div_a_q       <= 32'd0;
      div_b_q       <= 32'd0;
      b_lat_q       <= 32'd0;
      div_a_stb_q   <= 1'b0;
      div_b_stb_q   <= 1'b0;
      div_z_ack_q   <= 1'b0;
      done_count0_q <= 16'd0;
      done_count1_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      busy_q        <= busy_d;
      req0_ack_q    <= req0_ack_d;
      req1_ack_q    <= req1_ack_d;
      req0_z_q      <= req0_z_d;
      req1_z_q      <= req1_z_d;
      req0_z_stb_q  <= req0_z_stb_d;
      req1_z_stb_q  <= req1_z_stb_d;
      div_a_q       <= div_a_d;
      div_b_q       <= div_b_d;
      b_lat_q       <= b_lat_d;
      div_a_stb_q   <= div_a_stb_d;
      div_b_stb_q   <= div_b_stb_d;
      div_z_ack_q   <= div_z_ack_d;
      done_count0_q <= done_count0_d;
      done_count1_q <= done_count1_d;
    end
  end

  assign req0_ack    = req0_ack_q;
  assign req1_ack    = req1_ack_q;
  assign req0_z      = req0_z_q;
  assign req1_z      = req1_z_q;
  assign req0_z_stb  = req0_z_stb_q;
  assign req1_z_stb  = req1_z_stb_q;
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign div_a_stb   = div_a_stb_q;
  assign div_b_stb   = div_b_stb_q;
  assign div_z_ack   = div_z_ack_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign done_count0 = done_count0_q;
  assign done_count1 = done_count1_q;

endmodule

// File: doc/fp32_div_arbiter.md
FP32_DIV_ARBITER -- requirements
Module: fp32_div_arbiter

Interface
REQ-001 Parameter FAIR_RR, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with port 0 highest.
REQ-002 clock  in  1  single clock; all logic SHALL be on posedge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req0_a / req0_b  in  32 each  port-0 dividend / divisor (IEEE-754 single).
REQ-005 req0_stb  in  1  port-0 operand pair valid; held until accepted.
REQ-006 req0_ack  out  1  port-0 operand pair accepted when req0_stb && req0_ack at posedge.
REQ-007 req0_z  out  32  port-0 quotient.
REQ-008 req0_z_stb  out  1  port-0 quotient valid.
REQ-009 req0_z_ack  in  1  port-0 quotient consumed.
REQ-010 req1_* SHALL be identical to req0_* for port 1.
REQ-011 div_a / div_b  out  32 each  operands to divider; div_a_stb, div_b_stb out 1; div_a_ack, div_b_ack in 1.
REQ-012 div_z  in  32  divider result; div_z_stb in 1; div_z_ack out 1.
REQ-013 grant  out  1  port currently owning the divider; busy out 1, high in every state except IDLE.
REQ-014 done_count0 / done_count1  out  16 each  completed-operation counters per port.

Function
REQ-015 All handshakes SHALL transfer on a posedge where stb and ack are both high; all outputs SHALL be registered.
REQ-016 FSM states SHALL be IDLE, ACCEPT, SEND_A, SEND_B, WAIT_Z, RETURN.
REQ-017 IDLE: if any reqN_stb, grant SHALL be chosen, reqG_ack set 1, go ACCEPT; otherwise stay.
REQ-018 Arbitration with both stb high: FAIR_RR=1 grants the port not served last (last initialised to 1, so port 0 wins first); FAIR_RR=0 always grants port 0.
REQ-019 A single requester SHALL be granted regardless of last.
REQ-020 ACCEPT: on reqG_stb && reqG_ack, latch a and b, clear reqG_ack, go SEND_A; if reqG_stb is low, hold ack high and wait.
REQ-021 The non-granted port's ack SHALL stay 0 until it is granted.
REQ-022 SEND_A: div_a <= latched a, div_a_stb <= 1; on div_a_stb && div_a_ack, clear stb, go SEND_B.
REQ-023 SEND_B: same as SEND_A for b, then go WAIT_Z.
REQ-024 WAIT_Z: div_z_ack <= 1; on div_z_stb && div_z_ack, latch div_z, clear ack, go RETURN.
REQ-025 RETURN: reqG_z <= latched z, reqG_z_stb <= 1; on reqG_z_stb && reqG_z_ack, clear stb, set last <= grant, increment done_countG, go IDLE.
REQ-026 done_count SHALL wrap from 16'hFFFF to 0.
REQ-027 The arbiter SHALL pass z bit-exactly, including NaN, inf and zero; it SHALL do no arithmetic on operands.
REQ-028 The arbiter SHALL keep at most one operation outstanding; the divider SHALL never see a new a before the prior z is taken.
REQ-029 Back-pressure on reqG_z_ack SHALL stall in RETURN indefinitely, holding reqG_z stable.
REQ-030 reqN_z SHALL hold its last value after the strobe drops.

Reset
REQ-031 On reset: state IDLE; all *_ack, *_stb outputs 0; grant 0; busy 0; last 1; done_counts 0; z registers 0.
REQ-032 Reset mid-operation SHALL abandon the operation with no z_stb issued; the same reset SHALL drive the divider.

Verification
REQ-033 Port 0 sends 0x40C00000 / 0x40000000 -> req0_z = 0x40400000, done_count0 = 1, port 1 idle.
REQ-034 Both ports assert stb in the same cycle (FAIR_RR=1), port 0 1.0/4.0 and port 1 9.0/3.0 -> port 0 served first with 0x3E800000, then port 1 with 0x40400000.
REQ-035 Both ports hold stb continuously for 4 operations -> grants alternate 0,1,0,1; with FAIR_RR=0, port 0 is served every time.
REQ-036 Port 1 sends 0x3F800000 / 0x00000000 -> req1_z = 0x7F800000; 0x00000000 / 0x00000000 -> 0xFFC00000.
REQ-037 req0_z_ack held low for 20 cycles after z_stb -> req0_z stable, port 1 not granted, busy high; completion follows the ack.
REQ-038 Reset asserted in WAIT_Z -> next cycle all strobes and acks 0, state IDLE; a fresh request then completes correctly.
